cpu_top: RTL and testbench

//  Top-level wrapper for a minimal single-cycle MIPS32 integer core plus its instruction ROM.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/openmips.sv | 145 ++++++++++++++
 rtl/regfile.sv | 34 +++
 rtl/rom.sv | 14 +
 rtl/cpu_top.sv | 33 +++
 tb/tb_cpu_top.sv | 217 +++++++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the minimal MIPS32 integer core: opcode/funct
// encodings, ALU operation enum, and word / register-index types.
// Optional feature macro: MUL_EN (SPECIAL2 MUL instruction).
package cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // SPECIAL2 funct codes
    localparam logic [5:0] FN_MUL  = 6'h02;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MUL
    } alu_op_t;

    function automatic word_t sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic word_t zero_ext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/openmips.sv
// Single-cycle core: pc register, decode, ALU and the register file.
// Each clock executes the instruction presented on `instr` and writes its
// result at the same edge. Optional feature macro: MUL_EN.
module openmips
    import cpu_pkg::*;
#(
    parameter int          ROM_AW   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  word_t             instr,
    output logic [ROM_AW-1:0] rom_addr
);

    word_t    pc;
    logic [5:0] op, funct;
    reg_idx_t rs, rt, rd;
    logic [4:0] shamt;
    logic [15:0] imm;

    alu_op_t  alu_op;
    logic     use_imm;
    word_t    imm_val;
    reg_idx_t dest;
    logic     wr_en;
    logic     known;

    word_t rs_val, rt_val, opb, result;
    logic signed [31:0] sa, sb;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    // Word address wraps naturally at the ROM size; pc itself keeps 32 bits
    assign rom_addr = pc[ROM_AW+1:2];

    // Program counter: one instruction per clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    // Decode: select ALU op, operand source and destination; unknown encodings write nothing
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        imm_val = '0;
        dest    = rd;
        wr_en   = 1'b0;
        known   = 1'b0;
        // A word carrying X/Z reduces to X and falls through to the NOP path
        case (^instr)
            1'b0, 1'b1: known = 1'b1;
            default: ;
        endcase
        case (op)
            OP_SPECIAL: begin
                wr_en = 1'b1;
                case (funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    default: wr_en  = 1'b0;
                endcase
            end
            OP_ADDIU: begin alu_op = ALU_ADD;  use_imm = 1'b1; imm_val = sign_ext16(imm); dest = rt; wr_en = 1'b1; end
            OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; imm_val = sign_ext16(imm); dest = rt; wr_en = 1'b1; end
            OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; imm_val = sign_ext16(imm); dest = rt; wr_en = 1'b1; end
            OP_ANDI:  begin alu_op = ALU_AND;  use_imm = 1'b1; imm_val = zero_ext16(imm); dest = rt; wr_en = 1'b1; end
            OP_ORI:   begin alu_op = ALU_OR;   use_imm = 1'b1; imm_val = zero_ext16(imm); dest = rt; wr_en = 1'b1; end
            OP_XORI:  begin alu_op = ALU_XOR;  use_imm = 1'b1; imm_val = zero_ext16(imm); dest = rt; wr_en = 1'b1; end
            OP_LUI:   begin alu_op = ALU_LUI;  dest = rt; wr_en = 1'b1; end
`ifdef MUL_EN
            OP_SPECIAL2: begin
                if (funct == FN_MUL) begin
                    alu_op = ALU_MUL;
                    wr_en  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        if (!known) begin
            wr_en = 1'b0;
        end
    end

    regfile regfile (
        .clk (clk),
        .rst (rst),
        .ra  (rs),
        .rb  (rt),
        .da  (rs_val),
        .db  (rt_val),
        .we  (wr_en),
        .wa  (dest),
        .wd  (result)
    );

    assign opb = use_imm ? imm_val : rt_val;
    assign sa  = rs_val;
    assign sb  = opb;

    // ALU: all arithmetic modulo 2^32; shifts act on rt by shamt
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = rs_val + opb;
            ALU_SUB:  result = rs_val - opb;
            ALU_AND:  result = rs_val & opb;
            ALU_OR:   result = rs_val | opb;
            ALU_XOR:  result = rs_val ^ opb;
            ALU_NOR:  result = ~(rs_val | opb);
            ALU_SLT:  result = {31'b0, (sa < sb)};
            ALU_SLTU: result = {31'b0, (rs_val < opb)};
            ALU_SLL:  result = rt_val << shamt;
            ALU_SRL:  result = rt_val >> shamt;
            ALU_SRA:  result = sb >>> shamt;
            ALU_LUI:  result = {imm, 16'h0000};
`ifdef MUL_EN
            // Low half of the product is identical for signed and unsigned operands
            ALU_MUL:  result = sa * sb;
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port
// on posedge, asynchronous active-low clear of every entry. Register 0 is
// never written and always reads zero.
module regfile
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t ra,
    input  reg_idx_t rb,
    output word_t    da,
    output word_t    db,
    input  logic     we,
    input  reg_idx_t wa,
    input  word_t    wd
);

    reg [31:0] regs [0:31];

    // Clear all entries on reset; otherwise commit the write unless it targets $0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign da = (ra == 5'd0) ? '0 : regs[ra];
    assign db = (rb == 5'd0) ? '0 : regs[rb];

endmodule

// File: rtl/rom.sv
// Instruction ROM: 2**ROM_AW 32-bit words, combinational read.
// Contents are not reset; they are loaded hierarchically through `memory`.
module rom #(
    parameter int ROM_AW = 6
) (
    input  logic [ROM_AW-1:0] addr,
    output logic [31:0]       data
);

    reg [31:0] memory [0:2**ROM_AW-1];

    assign data = memory[addr];

endmodule

// File: rtl/cpu_top.sv
// Top level: instruction ROM plus single-cycle MIPS32 integer core.
// Optional feature macro: MUL_EN (enables SPECIAL2 MUL in the core).
module cpu_top
    import cpu_pkg::*;
#(
    parameter int          ROM_AW   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);

    word_t             instr;
    logic [ROM_AW-1:0] rom_addr;

    rom #(
        .ROM_AW (ROM_AW)
    ) rom (
        .addr (rom_addr),
        .data (instr)
    );

    openmips #(
        .ROM_AW   (ROM_AW),
        .RESET_PC (RESET_PC)
    ) openmips (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .rom_addr (rom_addr)
    );

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: directed program with known results, then random
// programs checked cycle by cycle against an instruction-level model.
module tb_cpu_top;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rom_img [0:63];
    logic [31:0] m_regs  [0:31];
    logic [31:0] m_pc;

    cpu_top dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
        logic [31:0] w;
        w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
        return w;
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [31:0] w;
        w = {op, 5'(rs), 5'(rt), imm};
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [11];
        logic [5:0] iops [7];
        int rs, rt, rd, sh;
        logic [15:0] imm;
        logic [31:0] w;
        fns  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        iops = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        rs  = $urandom_range(0, 7);
        rt  = $urandom_range(0, 7);
        rd  = $urandom_range(0, 7);
        sh  = $urandom_range(0, 31);
        imm = 16'($urandom);
        case ($urandom_range(0, 21))
            0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10: w = rtype(rs, rt, rd, sh, fns[$urandom_range(0, 10)]);
            11, 12, 13, 14, 15, 16, 17:       w = itype(iops[$urandom_range(0, 6)], rs, rt, imm);
            18:      w = itype(6'h3F, rs, rt, imm);
            19:      w = {6'h1C, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h02};
            20:      w = rtype(rs, rt, rd, sh, 6'h3F);
            default: w = itype(6'h0D, rs, rt, imm);
        endcase
        return w;
    endfunction

    // Instruction-level model: one architectural step from the bench's ROM image
    task automatic model_step();
        logic [31:0] w, a, b, res, simm, zimm;
        logic [5:0]  op, fn;
        int          dst, sh;
        bit          wr;
        w    = rom_img[m_pc[7:2]];
        op   = w[31:26];
        fn   = w[5:0];
        sh   = int'(w[10:6]);
        a    = m_regs[w[25:21]];
        b    = m_regs[w[20:16]];
        simm = {{16{w[15]}}, w[15:0]};
        zimm = {16'h0, w[15:0]};
        res  = 0;
        wr   = 1;
        dst  = int'(w[20:16]);
        if (op == 6'h00) begin
            dst = int'(w[15:11]);
            case (fn)
                6'h21: res = a + b;
                6'h23: res = a - b;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
                6'h2B: res = (a < b) ? 1 : 0;
                6'h00: res = b << sh;
                6'h02: res = b >> sh;
                6'h03: res = $signed(b) >>> sh;
                default: wr = 0;
            endcase
        end else begin
            case (op)
                6'h09: res = a + simm;
                6'h0A: res = ($signed(a) < $signed(simm)) ? 1 : 0;
                6'h0B: res = (a < simm) ? 1 : 0;
                6'h0C: res = a & zimm;
                6'h0D: res = a | zimm;
                6'h0E: res = a ^ zimm;
                6'h0F: res = {w[15:0], 16'h0};
`ifdef MUL_EN
                6'h1C: begin
                    dst = int'(w[15:11]);
                    if (fn == 6'h02) res = 32'($signed(a) * $signed(b));
                    else wr = 0;
                end
`endif
                default: wr = 0;
            endcase
        end
        if (wr && dst != 0) m_regs[dst] = res;
        m_pc = m_pc + 4;
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 64; i++) dut.rom.memory[i] = rom_img[i];
    endtask

    task automatic check_all(input string phase);
        chk($sformatf("%s pc", phase), dut.openmips.pc, m_pc);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s r%0d", phase, i), dut.openmips.regfile.regs[i], m_regs[i]);
        end
    endtask

    task automatic check_cleared(input string phase);
        chk($sformatf("%s pc", phase), dut.openmips.pc, 32'h0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s r%0d", phase, i), dut.openmips.regfile.regs[i], 32'h0);
        end
    endtask

    initial begin
        // Directed program followed by random filler
        rom_img[0]  = itype(6'h0D, 0, 1, 16'h8000);
        rom_img[1]  = itype(6'h09, 0, 2, 16'hFFFF);
        rom_img[2]  = rtype(1, 2, 3, 0, 6'h21);
        rom_img[3]  = rtype(1, 2, 4, 0, 6'h23);
        rom_img[4]  = rtype(2, 1, 3, 0, 6'h2A);
        rom_img[5]  = rtype(2, 1, 3, 0, 6'h2B);
        rom_img[6]  = itype(6'h0F, 0, 4, 16'h1234);
        rom_img[7]  = itype(6'h0D, 0, 0, 16'h0005);
        rom_img[8]  = 32'hFC00_0000;
        rom_img[9]  = itype(6'h09, 0, 5, 16'h0007);
        rom_img[10] = itype(6'h09, 0, 6, 16'hFFFD);
        rom_img[11] = {6'h1C, 5'd5, 5'd6, 5'd3, 5'd0, 6'h02};
        for (int i = 12; i < 64; i++) rom_img[i] = rand_instr();
        load_rom();

        #1 rst = 1'b0;
        model_reset();
        repeat (10) @(posedge clk);
        #1 check_cleared("reset");

        @(negedge clk) rst = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            @(posedge clk);
            #1;
            model_step();
            check_all("run1");
            case (c)
                1:  chk("ori r1",   dut.openmips.regfile.regs[1], 32'h0000_8000);
                2:  chk("addiu r2", dut.openmips.regfile.regs[2], 32'hFFFF_FFFF);
                3:  chk("addu r3",  dut.openmips.regfile.regs[3], 32'h0000_7FFF);
                4:  chk("subu r4",  dut.openmips.regfile.regs[4], 32'h0000_8001);
                5:  chk("slt r3",   dut.openmips.regfile.regs[3], 32'h0000_0001);
                6:  chk("sltu r3",  dut.openmips.regfile.regs[3], 32'h0000_0000);
                7:  chk("lui r4",   dut.openmips.regfile.regs[4], 32'h1234_0000);
                8:  chk("r0 hold",  dut.openmips.regfile.regs[0], 32'h0000_0000);
                9:  chk("nop pc",   dut.openmips.pc, 32'h0000_0024);
                10: chk("addiu r5", dut.openmips.regfile.regs[5], 32'h0000_0007);
                11: chk("addiu r6", dut.openmips.regfile.regs[6], 32'hFFFF_FFFD);
`ifdef MUL_EN
                12: chk("mul r3",   dut.openmips.regfile.regs[3], 32'hFFFF_FFEB);
`else
                12: chk("mul nop",  dut.openmips.regfile.regs[3], 32'h0000_0000);
`endif
                64: chk("wrap pc",  dut.openmips.pc, 32'h0000_0100);
                default: ;
            endcase
        end

        // Reset asserted mid-cycle clears state without waiting for a clock edge
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_cleared("midreset");
        model_reset();
        for (int i = 0; i < 64; i++) rom_img[i] = rand_instr();
        load_rom();
        repeat (3) @(posedge clk);
        #1 check_cleared("midhold");

        @(negedge clk) rst = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            model_step();
            check_all("run2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
